// File: rtl/io_bus_master_pkg.sv
// Shared definitions for io_bus_master: FSM state encoding, lane-index width
// helper and inactive levels of the active-low bus controls.
package io_bus_master_pkg;

    typedef enum logic [2:0] {
        IO_ST_IDLE   = 3'd0,
        IO_ST_SETUP  = 3'd1,
        IO_ST_STROBE = 3'd2,
        IO_ST_HOLD   = 3'd3,
        IO_ST_RESP   = 3'd4
    } io_state_e;

    localparam logic IO_STROBE_INACTIVE = 1'b1;
    localparam logic IO_CS_INACTIVE     = 1'b1;

    // Number of byte-address bits that select a lane within one bus word.
    function automatic int io_lane_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/io_lane_steer.sv
// Combinational byte-lane steering: write-byte replication, chip-select lane
// mask and read-byte extraction with zero extension.
module io_lane_steer
    import io_bus_master_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int LANES      = DATA_WIDTH / 8,
    localparam int LANE_W     = io_lane_w(DATA_WIDTH)
) (
    input  logic [LANE_W-1:0]     i_lane,
    input  logic                  i_word,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [LANES-1:0]      o_cs_mask,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    always_comb begin
        o_wdata   = i_word ? i_wdata : {LANES{i_wdata[7:0]}};
        o_cs_mask = '0;
        o_rdata   = '0;
        if (i_word) begin
            o_cs_mask = '1;
            o_rdata   = i_rdata;
        end else begin
            o_cs_mask[i_lane] = 1'b1;
            o_rdata[7:0]      = i_rdata[{i_lane, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/io_bus_master.sv
// Timed external I/O bus master: SETUP/STROBE/HOLD phases with device ready.
// Optional strobe timeout is enabled by defining IO_TIMEOUT_EN.
module io_bus_master
    import io_bus_master_pkg::*;
#(
    parameter  int DATA_WIDTH     = 16,
    parameter  int ADDR_WIDTH     = 16,
    parameter  int SETUP_CYCLES   = 1,
    parameter  int STROBE_CYCLES  = 1,
    parameter  int HOLD_CYCLES    = 1,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int LANES          = DATA_WIDTH / 8,
    localparam int LANE_W         = io_lane_w(DATA_WIDTH),
    localparam int WADDR_W        = ADDR_WIDTH - LANE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_word,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [WADDR_W-1:0]    io_addr,
    output logic [DATA_WIDTH-1:0] io_data_out,
    output logic                  io_data_oe,
    input  logic [DATA_WIDTH-1:0] io_data_in,
    output logic [LANES-1:0]      io_cs_n,
    output logic                  io_rd_n,
    output logic                  io_wr_n,
    input  logic                  io_ready,
    output io_state_e             dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; resp_valid is a single-cycle pulse that the
    // requester must take, there is no response backpressure.

`ifdef IO_TIMEOUT_EN
    localparam int STROBE_SPAN = STROBE_CYCLES + TIMEOUT_CYCLES;
`else
    localparam int STROBE_SPAN = STROBE_CYCLES;
`endif
    localparam int CNT_MAX_A = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > STROBE_SPAN) ? CNT_MAX_A : STROBE_SPAN;
    localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    io_state_e               r_state, w_nxt_state;
    logic [CNT_W-1:0]        r_cnt, w_nxt_cnt;
    logic [LANE_W-1:0]       r_lane, w_nxt_lane;
    logic                    r_word, w_nxt_word;
    logic                    r_write, w_nxt_write;
    logic [WADDR_W-1:0]      r_io_addr, w_nxt_addr;
    logic [DATA_WIDTH-1:0]   r_io_data_out, w_nxt_dout;
    logic                    r_io_data_oe, w_nxt_oe;
    logic [LANES-1:0]        r_io_cs_n, w_nxt_cs_n;
    logic                    r_io_rd_n, w_nxt_rd_n;
    logic                    r_io_wr_n, w_nxt_wr_n;
    logic                    r_resp_valid;
    logic                    r_resp_error, w_nxt_rerr;
    logic [DATA_WIDTH-1:0]   r_resp_rdata, w_nxt_rdata;

    logic [LANE_W-1:0]       w_req_lane;
    logic [LANE_W-1:0]       w_st_lane;
    logic                    w_st_word;
    logic [DATA_WIDTH-1:0]   w_st_wdata;
    logic [DATA_WIDTH-1:0]   w_st_rdata;
    logic [LANES-1:0]        w_cs_mask;
    logic                    w_misaligned;
    logic                    w_min_met;
    logic                    w_strobe_ok;
    logic                    w_timeout;
    logic                    w_cnt_run;

    assign w_req_lane   = req_addr[LANE_W-1:0];
    assign w_misaligned = req_word && (w_req_lane != '0);
    // While idle the steering works on the incoming request so SETUP can
    // present lane-correct data at the acceptance edge.
    assign w_st_lane    = (r_state == IO_ST_IDLE) ? w_req_lane : r_lane;
    assign w_st_word    = (r_state == IO_ST_IDLE) ? req_word   : r_word;
    assign w_min_met    = (int'(r_cnt) + 1) >= STROBE_CYCLES;
    assign w_strobe_ok  = w_min_met && io_ready;

`ifdef IO_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(STROBE_SPAN - 1);
    assign w_timeout = (r_state == IO_ST_STROBE) && !w_strobe_ok && (r_cnt == TIMEOUT_LAST);
    assign w_cnt_run = 1'b1;
`else
    assign w_timeout = 1'b0;
    // Counter saturates once the minimum strobe width is reached.
    assign w_cnt_run = !w_min_met;
`endif

    io_lane_steer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_steer (
        .i_lane    (w_st_lane),
        .i_word    (w_st_word),
        .i_wdata   (req_wdata),
        .i_rdata   (io_data_in),
        .o_wdata   (w_st_wdata),
        .o_cs_mask (w_cs_mask),
        .o_rdata   (w_st_rdata)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_lane  = r_lane;
        w_nxt_word  = r_word;
        w_nxt_write = r_write;
        w_nxt_addr  = r_io_addr;
        w_nxt_dout  = r_io_data_out;
        w_nxt_oe    = r_io_data_oe;
        w_nxt_cs_n  = r_io_cs_n;
        w_nxt_rd_n  = r_io_rd_n;
        w_nxt_wr_n  = r_io_wr_n;
        w_nxt_rerr  = r_resp_error;
        w_nxt_rdata = r_resp_rdata;
        case (r_state)
            IO_ST_IDLE: begin
                if (req_valid) begin
                    w_nxt_lane  = w_req_lane;
                    w_nxt_word  = req_word;
                    w_nxt_write = req_write;
                    w_nxt_cnt   = '0;
                    w_nxt_rdata = '0;
                    w_nxt_rerr  = w_misaligned;
                    if (w_misaligned) begin
                        w_nxt_state = IO_ST_RESP;
                    end else begin
                        w_nxt_state = IO_ST_SETUP;
                        w_nxt_addr  = req_addr[ADDR_WIDTH-1:LANE_W];
                        w_nxt_cs_n  = ~w_cs_mask;
                        w_nxt_oe    = req_write;
                        if (req_write) begin
                            w_nxt_dout = w_st_wdata;
                        end
                    end
                end
            end
            IO_ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_nxt_state = IO_ST_STROBE;
                    w_nxt_cnt   = '0;
                    w_nxt_rd_n  = r_write ? IO_STROBE_INACTIVE : ~IO_STROBE_INACTIVE;
                    w_nxt_wr_n  = r_write ? ~IO_STROBE_INACTIVE : IO_STROBE_INACTIVE;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_ONE;
                end
            end
            IO_ST_STROBE: begin
                if (w_strobe_ok || w_timeout) begin
                    w_nxt_state = IO_ST_HOLD;
                    w_nxt_cnt   = '0;
                    w_nxt_rd_n  = IO_STROBE_INACTIVE;
                    w_nxt_wr_n  = IO_STROBE_INACTIVE;
                    w_nxt_rerr  = w_timeout;
                    w_nxt_rdata = (w_timeout || r_write) ? '0 : w_st_rdata;
                end else if (w_cnt_run) begin
                    w_nxt_cnt = r_cnt + CNT_ONE;
                end
            end
            IO_ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_nxt_state = IO_ST_RESP;
                    w_nxt_cnt   = '0;
                    w_nxt_cs_n  = {LANES{IO_CS_INACTIVE}};
                    w_nxt_oe    = 1'b0;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_ONE;
                end
            end
            IO_ST_RESP: begin
                w_nxt_state = IO_ST_IDLE;
            end
            default: begin
                w_nxt_state = IO_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IO_ST_IDLE;
            r_cnt         <= '0;
            r_lane        <= '0;
            r_word        <= 1'b0;
            r_write       <= 1'b0;
            r_io_addr     <= '0;
            r_io_data_out <= '0;
            r_io_data_oe  <= 1'b0;
            r_io_cs_n     <= {LANES{IO_CS_INACTIVE}};
            r_io_rd_n     <= IO_STROBE_INACTIVE;
            r_io_wr_n     <= IO_STROBE_INACTIVE;
            r_resp_valid  <= 1'b0;
            r_resp_error  <= 1'b0;
            r_resp_rdata  <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_lane        <= w_nxt_lane;
            r_word        <= w_nxt_word;
            r_write       <= w_nxt_write;
            r_io_addr     <= w_nxt_addr;
            r_io_data_out <= w_nxt_dout;
            r_io_data_oe  <= w_nxt_oe;
            r_io_cs_n     <= w_nxt_cs_n;
            r_io_rd_n     <= w_nxt_rd_n;
            r_io_wr_n     <= w_nxt_wr_n;
            r_resp_valid  <= (w_nxt_state == IO_ST_RESP);
            r_resp_error  <= w_nxt_rerr;
            r_resp_rdata  <= w_nxt_rdata;
        end
    end

    assign req_ready   = (r_state == IO_ST_IDLE) && !reset;
    assign resp_valid  = r_resp_valid;
    assign resp_error  = r_resp_error;
    assign resp_rdata  = r_resp_rdata;
    assign io_addr     = r_io_addr;
    assign io_data_out = r_io_data_out;
    assign io_data_oe  = r_io_data_oe;
    assign io_cs_n     = r_io_cs_n;
    assign io_rd_n     = r_io_rd_n;
    assign io_wr_n     = r_io_wr_n;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master: random requests, reactive device
// model driving io_ready, bus-phase monitor and response scoreboard.
module tb_io_bus_master;
    import io_bus_master_pkg::*;

    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int LANES   = 2;
    localparam int LW      = 1;
    localparam int SETUP   = 1;
    localparam int STROBE  = 1;
    localparam int HOLD    = 1;
    localparam int TIMEOUT = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic              req_word = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [DW-1:0]     req_wdata = '0;
    logic              resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              resp_error;
    logic [AW-LW-1:0]  io_addr;
    logic [DW-1:0]     io_data_out;
    logic              io_data_oe;
    logic [DW-1:0]     io_data_in = '0;
    logic [LANES-1:0]  io_cs_n;
    logic              io_rd_n;
    logic              io_wr_n;
    logic              io_ready = 1'b0;
    io_state_e         dbg_state;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int cur_waits = 0;

    typedef struct packed {
        logic [31:0]   due;
        logic          chk_rdata;
        logic          err;
        logic [DW-1:0] rdata;
    } resp_t;

    typedef struct packed {
        logic [AW-LW-1:0] addr;
        logic [LANES-1:0] cs_n;
        logic             wr;
        logic [DW-1:0]    dout;
        logic [7:0]       len;
    } bus_t;

    resp_t exp_q[$];
    bus_t  exp_bus_q[$];

    io_bus_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .SETUP_CYCLES   (SETUP),
        .STROBE_CYCLES  (STROBE),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_word    (req_word),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .io_addr     (io_addr),
        .io_data_out (io_data_out),
        .io_data_oe  (io_data_oe),
        .io_data_in  (io_data_in),
        .io_cs_n     (io_cs_n),
        .io_rd_n     (io_rd_n),
        .io_wr_n     (io_wr_n),
        .io_ready    (io_ready),
        .dbg_state   (dbg_state)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    // Device: asserts ready once the strobe has been low STROBE+waits cycles;
    // random level elsewhere, which the master must ignore.
    initial begin : device
        int low_k;
        low_k = 0;
        forever begin
            @(negedge clock);
            if (!io_rd_n || !io_wr_n) low_k++;
            else low_k = 0;
            if (low_k > 0) io_ready = (low_k >= STROBE + cur_waits);
            else io_ready = 1'($urandom_range(0, 1));
        end
    end

    // Bus monitor: checks phase lengths and held address/select/data.
    initial begin : bus_mon
        bit   in_acc;
        int   n_setup, n_strobe, n_hold;
        bus_t cur;
        in_acc = 0; n_setup = 0; n_strobe = 0; n_hold = 0; cur = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_acc = 0;
            end else if (io_cs_n != '1) begin
                if (!in_acc) begin
                    in_acc = 1; n_setup = 0; n_strobe = 0; n_hold = 0;
                    if (exp_bus_q.size() == 0) begin
                        fail_now("bus_unexpected", $sformatf("cs_n=%b with no access expected", io_cs_n));
                        cur = '0;
                    end else begin
                        cur = exp_bus_q.pop_front();
                    end
                end
                chk("bus_addr", 32'(io_addr), 32'(cur.addr));
                chk("bus_cs_n", 32'(io_cs_n), 32'(cur.cs_n));
                chk("bus_oe", 32'(io_data_oe), 32'(cur.wr));
                if (cur.wr) chk("bus_dout", 32'(io_data_out), 32'(cur.dout));
                if (!io_rd_n || !io_wr_n) begin
                    n_strobe++;
                    chk("bus_strobe_kind", {30'd0, io_rd_n, io_wr_n}, cur.wr ? 32'd2 : 32'd1);
                end else if (n_strobe == 0) begin
                    n_setup++;
                end else begin
                    n_hold++;
                end
            end else if (in_acc) begin
                in_acc = 0;
                chk("bus_setup_len", n_setup, SETUP);
                chk("bus_strobe_len", n_strobe, 32'(cur.len));
                chk("bus_hold_len", n_hold, HOLD);
            end else begin
                chk("bus_idle_ctl", {29'd0, io_rd_n, io_wr_n, io_data_oe}, 32'd6);
            end
        end
    end

    // Response monitor / scoreboard
    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge clock);
            if (!reset && resp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("resp_unexpected", $sformatf("resp_valid with err=%0d rdata=0x%0h, none expected", resp_error, resp_rdata));
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_error", 32'(resp_error), 32'(e.err));
                    if (e.chk_rdata) chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    // Driver: issues one request and pushes the reference-model expectations.
    task automatic issue(input logic wr, input logic wd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] bus, input int waits);
        int            guard;
        int            acc;
        int unsigned   lane;
        bit            mis, tmo;
        int            slen;
        resp_t         e;
        bus_t          b;
        logic [DW-1:0] dv;
        logic [LANES-1:0] cs;
        guard = 0;
        @(negedge clock);
        while (!req_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            fail_now("req_ready_wait", "req_ready stayed low for 100 cycles, want 1");
            return;
        end
        io_data_in = bus;
        cur_waits  = waits;
        req_valid  = 1'b1;
        req_write  = wr;
        req_word   = wd;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        acc = cyc;

        lane = addr % LANES;
        mis  = wd && (lane != 0);
        tmo  = 0;
`ifdef IO_TIMEOUT_EN
        tmo  = !mis && (waits > TIMEOUT);
`endif
        slen = tmo ? STROBE + TIMEOUT : STROBE + waits;
        e.err       = mis || tmo;
        e.due       = mis ? acc : acc + SETUP + slen + HOLD;
        e.chk_rdata = !mis && (!wr || tmo);
        e.rdata     = tmo ? '0 : (wd ? bus : ((bus >> (8 * lane)) & 16'h00FF));
        exp_q.push_back(e);
        if (!mis) begin
            dv = wdata;
            if (!wd) for (int i = 0; i < LANES; i++) dv[8*i +: 8] = wdata[7:0];
            cs = '1;
            if (wd) cs = '0;
            else cs[lane] = 1'b0;
            b.addr = addr / LANES;
            b.cs_n = cs;
            b.wr   = wr;
            b.dout = dv;
            b.len  = 8'(slen);
            exp_bus_q.push_back(b);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_n"}, 32'(io_rd_n), 32'd1);
        chk({tag, "_wr_n"}, 32'(io_wr_n), 32'd1);
        chk({tag, "_cs_n"}, 32'(io_cs_n), 32'd3);
        chk({tag, "_oe"}, 32'(io_data_oe), 32'd0);
        chk({tag, "_addr"}, 32'(io_addr), 32'd0);
        chk({tag, "_dout"}, 32'(io_data_out), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_error"}, 32'(resp_error), 32'd0);
        chk({tag, "_resp_rdata"}, 32'(resp_rdata), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IO_ST_IDLE));
    endtask

    task automatic random_txns(input int n);
        logic wr, wd;
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            issue(wr, wd, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                  16'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 6)));
        end
    endtask

    initial begin : main
        int guard;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_idle_outputs("por");
        reset = 1'b0;
        @(negedge clock);
        chk("por_ready_after", 32'(req_ready), 32'd1);

        issue(1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 0);
        issue(1'b0, 1'b0, 16'h0011, 16'h0000, 16'hA55A, 0);
        issue(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h1111, 0);
        issue(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hC3C3, 3);
        issue(1'b1, 1'b0, 16'h0021, 16'h1277, 16'h0000, 1);
        issue(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h5AA5, 2);
`ifdef IO_TIMEOUT_EN
        issue(1'b0, 1'b1, 16'h0050, 16'h0000, 16'h9999, 100);
`endif
        random_txns(60);

        // Reset in the middle of a strobe aborts the access without a response.
        issue(1'b0, 1'b1, 16'h0020, 16'h0000, 16'h1234, 20);
        guard = 0;
        while (io_rd_n && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (io_rd_n) fail_now("rst_strobe_wait", "io_rd_n never went low, want 0");
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_idle_outputs("rst");
        exp_q.delete();
        exp_bus_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready_after", 32'(req_ready), 32'd1);

        random_txns(30);

        guard = 0;
        while ((exp_q.size() != 0 || exp_bus_q.size() != 0) && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        chk("drain_resp_q", exp_q.size(), 0);
        chk("drain_bus_q", exp_bus_q.size(), 0);
        repeat (5) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
